fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the next-generation pipelined MIPS core. It replaces the free-running PC plus combinational PC+4/branch/jump mux chain of the single-cycle datapath. It issues word addresses to a synchronous instruction memory with 1-cycle read latency and buffers returned instructions in a small flushable FIFO. It presents them to decode over a valid/ready handshake, applies branch/jump/jr redirects with squash of in-flight fetches, and traps on misaligned or out-of-range targets.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_buffer.sv | 71 +++++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM states, redirect kind codes
// and the NOP word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [1:0] RDR_BRANCH = 2'b00;
    localparam logic [1:0] RDR_JUMP   = 2'b01;
    localparam logic [1:0] RDR_JR     = 2'b10;

    localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs; flush empties
// it at the next edge and push+pop is accepted even when full.
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign valid     = (count_q != '0);
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues word reads to a 1-cycle synchronous imem,
// buffers returns, hands them to decode and applies redirects/fault trapping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter int               IMEM_DEPTH   = 64,
    parameter int               BUF_DEPTH    = 2,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_kind,
    input  logic [XLEN-1:0] redirect_pc4,
    input  logic [25:0]     redirect_imm,
    input  logic [XLEN-1:0] redirect_reg,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam int              CW       = $clog2(BUF_DEPTH + 1);
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH * 4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pending_q, pending_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     last_instr_q, last_instr_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [XLEN-1:0] last_pc4_q, last_pc4_d;

    logic [XLEN-1:0]    target;
    logic               rdr_active, rdr_legal, rdr_fault;
    logic               consume, push;
    logic [CW:0]        need;
    logic [32+XLEN-1:0] buf_head;
    logic               buf_valid;
    logic [CW-1:0]      buf_count;

    always_comb begin
        case (redirect_kind)
            RDR_BRANCH: target = redirect_pc4 +
                {{(XLEN-18){redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
            RDR_JUMP:   target = {redirect_pc4[XLEN-1:28], redirect_imm, 2'b00};
            default:    target = redirect_reg;
        endcase
        rdr_active = redirect_valid && (redirect_kind != 2'b11) && (state_q != FS_FAULT);
        rdr_legal  = rdr_active && (target[1:0] == 2'b00) && (target < PC_LIMIT);
        rdr_fault  = rdr_active && !rdr_legal;
    end

    // A request is only made if its response is guaranteed a free slot.
    always_comb begin
        if_valid = buf_valid && (state_q != FS_FAULT);
        consume  = if_valid && if_ready;
        push     = pending_q && !rdr_active && (state_q != FS_FAULT);
        need     = {1'b0, buf_count} + (CW+1)'(pending_q) - (CW+1)'(consume);
        imem_en  = !reset && (state_q != FS_FAULT) && !rdr_active &&
                   (need < (CW+1)'(BUF_DEPTH));
        imem_addr = pc_q;
    end

    always_comb begin
        state_d = (state_q == FS_IDLE) ? FS_RUN : state_q;
        if (rdr_fault) state_d = FS_FAULT;
        pc_d = imem_en ? pc_q + XLEN'(4) : pc_q;
        if (rdr_legal) pc_d = target;
        pend_pc_d    = imem_en ? pc_q : pend_pc_q;
        pending_d    = imem_en;
        fault_d      = fault_q || rdr_fault;
        fault_pc_d   = rdr_fault ? target : fault_pc_q;
        last_instr_d = buf_valid ? buf_head[32+XLEN-1:XLEN] : last_instr_q;
        last_pc_d    = buf_valid ? buf_head[XLEN-1:0] : last_pc_q;
        last_pc4_d   = buf_valid ? buf_head[XLEN-1:0] + XLEN'(4) : last_pc4_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_VECTOR;
            pend_pc_q    <= RESET_VECTOR;
            pending_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_pc_q   <= '0;
            last_instr_q <= NOP;
            last_pc_q    <= '0;
            last_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pending_q    <= pending_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
            last_instr_q <= last_instr_d;
            last_pc_q    <= last_pc_d;
            last_pc4_q   <= last_pc4_d;
        end
    end

    fetch_buffer #(
        .WIDTH (32 + XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (rdr_active),
        .push      (push),
        .push_data ({imem_rdata, pend_pc_q}),
        .pop       (consume),
        .head_data (buf_head),
        .valid     (buf_valid),
        .count     (buf_count)
    );

    // With the buffer empty the last delivered values stay on the outputs.
    assign if_instr = buf_valid ? buf_head[32+XLEN-1:XLEN] : last_instr_q;
    assign if_pc    = buf_valid ? buf_head[XLEN-1:0] : last_pc_q;
    assign if_pc4   = buf_valid ? buf_head[XLEN-1:0] + XLEN'(4) : last_pc4_q;
    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued when a stream is
// started or redirected and popped on every decode handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr, if_pc, if_pc4;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_kind = 2'b00;
    logic [31:0] redirect_pc4 = 32'h0;
    logic [25:0] redirect_imm = 26'h0;
    logic [31:0] redirect_reg = 32'h0;
    logic        fault;
    logic [31:0] fault_pc;

    int num_checks = 0;
    int num_errors = 0;
    int xfers = 0;
    int cyc = 0;
    int first_en = -1;
    int first_v = -1;
    int used;
    logic [31:0] exp_q[$];

    fetch_unit #(
        .XLEN(32), .IMEM_DEPTH(64), .BUF_DEPTH(2), .RESET_VECTOR(32'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc4(if_pc4),
        .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
        .redirect_pc4(redirect_pc4), .redirect_imm(redirect_imm),
        .redirect_reg(redirect_reg),
        .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic noteEvents();
        if (imem_en && first_en < 0) first_en = cyc;
        if (if_valid && first_v < 0) first_v = cyc;
    endtask

    task automatic pushStream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic applyStimulus(input logic rdy, input logic rv, input logic [1:0] kind,
                                 input logic [31:0] pc4, input logic [25:0] imm,
                                 input logic [31:0] rreg);
        logic [31:0] e;
        @(negedge clk);
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_kind  = kind;
        redirect_pc4   = pc4;
        redirect_imm   = imm;
        redirect_reg   = rreg;
        #1;
        cyc++;
        noteEvents();
        if (if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("extra_xfer", if_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("if_pc", if_pc, e);
                checkOutput("if_instr", if_instr, mem_word(e));
                checkOutput("if_pc4", if_pc4, e + 32'd4);
            end
            xfers++;
        end
    endtask

    task automatic runUntil(input int n, output int cycles);
        int start;
        start  = xfers;
        cycles = 0;
        while ((xfers - start) < n && cycles < 100) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
            cycles++;
        end
        if ((xfers - start) < n) checkOutput("timeout", 32'(xfers - start), 32'(n));
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_imem_en", 32'(imem_en), 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_pc4", if_pc4, 32'h0);
        checkOutput("rst_fault", 32'(fault), 32'h0);
        checkOutput("rst_fault_pc", fault_pc, 32'h0);
        reset = 1'b0;
        #1;
        cyc = 0;
        first_en = -1;
        first_v = -1;
        noteEvents();
        pushStream(32'h0);
    endtask

    initial begin
        // Start-up latency and sustained throughput.
        doReset();
        for (int i = 0; i < 10 && first_v < 0; i++)
            applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        checkOutput("first_latency", 32'(first_v - first_en), 32'd2);
        runUntil(6, used);
        checkOutput("throughput", 32'(used), 32'd6);

        // Stall with 0x8 at the head, then release.
        doReset();
        runUntil(2, used);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
            checkOutput("stall_pc", if_pc, 32'h8);
            checkOutput("stall_instr", if_instr, mem_word(32'h8));
            checkOutput("stall_valid", 32'(if_valid), 32'h1);
            checkOutput("stall_imem_en", 32'(imem_en), 32'h0);
        end
        runUntil(3, used);
        checkOutput("release_gapless", 32'(used), 32'd3);

        // Branch back to 0x04 from pc4=0x0C.
        pushStream(32'h4);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0C, 26'h0FFFE, 32'h0);
        runUntil(4, used);

        // Jump with a same-cycle head transfer, then to 0x40.
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h10, 26'h10, 32'h0);
        pushStream(32'h40);
        runUntil(3, used);

        // Reserved kind leaves the stream untouched.
        applyStimulus(1'b1, 1'b1, 2'b11, 32'h0, 26'h0, 32'h200);
        runUntil(3, used);

        // Misaligned jr target traps; later redirects are ignored.
        exp_q.delete();
        applyStimulus(1'b0, 1'b1, 2'b10, 32'h0, 26'h0, 32'h102);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, (i == 1), 2'b00, 32'h10, 26'h0, 32'h0);
            checkOutput("jr_fault", 32'(fault), 32'h1);
            checkOutput("jr_fault_pc", fault_pc, 32'h102);
            checkOutput("jr_if_valid", 32'(if_valid), 32'h0);
            checkOutput("jr_imem_en", 32'(imem_en), 32'h0);
        end

        // Branch to 0x100, one past the end of a 64-word memory.
        doReset();
        runUntil(2, used);
        exp_q.delete();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 26'h40, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        checkOutput("range_fault", 32'(fault), 32'h1);
        checkOutput("range_fault_pc", fault_pc, 32'h100);

        // Reset mid-stream with a fetch in flight; restart at the vector.
        doReset();
        runUntil(3, used);
        doReset();
        runUntil(4, used);

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule
